// File: rtl/hwce_arb_pkg.sv
// Shared constants and helpers for the HWCE-to-TCDM banked arbiter.
// Index widths are derived here so every file sizes its indices the same way.
package hwce_arb_pkg;

   localparam int N_MASTERS_DEF = 4;
   localparam int N_SLAVES_DEF  = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MST_IDX_W  = idx_w(N_MASTERS_DEF);
   localparam int BANK_IDX_W = idx_w(N_SLAVES_DEF);

   function automatic logic [31:0] sat_add32(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/hwce_rr_arb.sv
// Round-robin arbiter for one TCDM bank: one-hot grant plus winner index.
// Search starts at the stored pointer, which moves past each winner.
import hwce_arb_pkg::*;

module hwce_rr_arb #(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req,
   output logic [N-1:0]        gnt,
   output logic [idx_w(N)-1:0] idx,
   output logic                valid
);

   localparam int W = idx_w(N);

   logic [W-1:0] ptr;
   logic [W-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = W'((int'(ptr) + i) % N);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (valid) begin
         ptr <= (int'(idx) == N - 1) ? '0 : idx + W'(1);
      end
   end

endmodule

// File: rtl/hwce_tcdm_bank_arbiter.sv
// Arbitrated HWCE-to-TCDM interconnect: per-bank round-robin, registered response.
// Optional conflict counter enabled by defining HWCE_ARB_PERF_EN.
import hwce_arb_pkg::*;

module hwce_tcdm_bank_arbiter #(
   parameter int          N_MASTERS       = 4,
   parameter int          N_SLAVES        = 8,
   parameter int          ADDR_WIDTH      = 32,
   parameter int          DATA_WIDTH      = 32,
   parameter int          BE_WIDTH        = DATA_WIDTH / 8,
   parameter int          ADDR_SRAM_WIDTH = 10,
   parameter int          LSB_ADDR        = 17,
   parameter logic [31:0] ADDR_OFFSET     = 32'h0006_0000
) (
   input  logic                                clk,
   input  logic                                rst_n,
`ifdef HWCE_ARB_PERF_EN
   input  logic                                perf_clr_i,
   output logic [31:0]                         conflict_cnt_o,
`endif
   input  logic [N_MASTERS-1:0]                data_req_i,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]     data_add_i,
   input  logic [N_MASTERS-1:0]                data_wen_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]     data_wdata_i,
   input  logic [N_MASTERS*BE_WIDTH-1:0]       data_be_i,
   output logic [N_MASTERS-1:0]                data_gnt_o,
   output logic [N_MASTERS-1:0]                data_r_valid_o,
   output logic [N_MASTERS*DATA_WIDTH-1:0]     data_r_rdata_o,
   output logic [N_SLAVES-1:0]                 data_req_SRAM_o,
   output logic [N_SLAVES*ADDR_SRAM_WIDTH-1:0] data_add_SRAM_o,
   output logic [N_SLAVES-1:0]                 data_wen_SRAM_o,
   output logic [N_SLAVES*DATA_WIDTH-1:0]      data_wdata_SRAM_o,
   output logic [N_SLAVES*BE_WIDTH-1:0]        data_be_SRAM_o,
   input  logic [N_SLAVES*DATA_WIDTH-1:0]      data_r_rdata_SRAM_i
);

   localparam int MW = idx_w(N_MASTERS);
   localparam int SB = idx_w(N_SLAVES);
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int BW = BE_WIDTH;
   localparam int SW = ADDR_SRAM_WIDTH;

   logic [AW-1:0]        rel       [N_MASTERS];
   logic [SB-1:0]        bank      [N_MASTERS];
   logic [N_MASTERS-1:0] bank_req  [N_SLAVES];
   logic [N_MASTERS-1:0] bank_gnt  [N_SLAVES];
   logic [MW-1:0]        win       [N_SLAVES];
   logic [N_SLAVES-1:0]  bank_vld;
   logic [N_MASTERS-1:0] r_valid;
   logic [SB-1:0]        resp_bank [N_MASTERS];

   // Out-of-window addresses simply alias onto a bank
   always_comb begin
      for (int m = 0; m < N_MASTERS; m++) begin
         rel[m]  = data_add_i[m*AW +: AW] - AW'(ADDR_OFFSET);
         bank[m] = (N_SLAVES > 1) ? SB'(rel[m] >> LSB_ADDR) : '0;
      end
   end

   always_comb begin
      for (int b = 0; b < N_SLAVES; b++) begin
         for (int m = 0; m < N_MASTERS; m++) begin
            bank_req[b][m] = data_req_i[m] && (int'(bank[m]) == b);
         end
      end
   end

   for (genvar b = 0; b < N_SLAVES; b++) begin : g_bank
      hwce_rr_arb #(
         .N(N_MASTERS)
      ) u_arb (
         .clk  (clk),
         .rst_n(rst_n),
         .req  (bank_req[b]),
         .gnt  (bank_gnt[b]),
         .idx  (win[b]),
         .valid(bank_vld[b])
      );
   end

   always_comb begin
      data_gnt_o = '0;
      for (int b = 0; b < N_SLAVES; b++) begin
         data_gnt_o = data_gnt_o | bank_gnt[b];
      end
   end

   always_comb begin
      data_req_SRAM_o   = '0;
      data_add_SRAM_o   = '0;
      data_wen_SRAM_o   = '0;
      data_wdata_SRAM_o = '0;
      data_be_SRAM_o    = '0;
      for (int b = 0; b < N_SLAVES; b++) begin
         if (bank_vld[b]) begin
            data_req_SRAM_o[b]          = 1'b1;
            data_add_SRAM_o[b*SW +: SW] =
               data_add_i[int'(win[b])*AW + 2 +: SW];
            data_wen_SRAM_o[b]          = data_wen_i[win[b]];
            data_wdata_SRAM_o[b*DW +: DW] =
               data_wdata_i[int'(win[b])*DW +: DW];
            data_be_SRAM_o[b*BW +: BW]  =
               data_be_i[int'(win[b])*BW +: BW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int m = 0; m < N_MASTERS; m++) begin
            resp_bank[m] <= '0;
         end
      end else begin
         r_valid <= data_gnt_o;
         for (int m = 0; m < N_MASTERS; m++) begin
            if (data_gnt_o[m]) begin
               resp_bank[m] <= bank[m];
            end
         end
      end
   end

   always_comb begin
      data_r_valid_o = r_valid;
      data_r_rdata_o = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         if (r_valid[m]) begin
            data_r_rdata_o[m*DW +: DW] =
               data_r_rdata_SRAM_i[int'(resp_bank[m])*DW +: DW];
         end
      end
   end

`ifdef HWCE_ARB_PERF_EN
   logic [31:0] n_conf;
   logic [31:0] conf_cnt;

   always_comb begin
      n_conf = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         n_conf = n_conf + 32'(data_req_i[m] & ~data_gnt_o[m]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conf_cnt <= '0;
      end else if (perf_clr_i) begin
         conf_cnt <= '0;
      end else begin
         conf_cnt <= sat_add32(conf_cnt, n_conf);
      end
   end

   assign conflict_cnt_o = conf_cnt;
`endif

endmodule

// File: doc/hwce_tcdm_bank_arbiter.md
Name: hwce_tcdm_bank_arbiter

Overview:
- Arbitrated replacement for the conflict-free point-to-point HWCE-to-TCDM crossbar.
- N_MASTERS HWCE ports share N_SLAVES SRAM banks. The target bank is decoded from the address window. Each bank has its own round-robin arbiter.
- Returns a grant, then a registered response one cycle after the grant.
- Sits between the HWCE engine ports and the SRAM bank macros. Same bank-side signals as the unarbitrated path; single lane per master.

Parameters:
- N_MASTERS, 4, HWCE requester ports; must be >=2.
- N_SLAVES, 8, SRAM banks; must be a power of 2.
- ADDR_WIDTH, 32, master address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_SRAM_WIDTH, 10, bank word-address width.
- LSB_ADDR, 17, lowest bank-select address bit.
- ADDR_OFFSET, 32'h00060000, base of the TCDM window.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  N_MASTERS  master request
- data_add_i  in  N_MASTERS*ADDR_WIDTH  byte address
- data_wen_i  in  N_MASTERS  0=store, 1=load
- data_wdata_i  in  N_MASTERS*DATA_WIDTH  write data
- data_be_i  in  N_MASTERS*BE_WIDTH  byte enables
- data_gnt_o  out  N_MASTERS  grant, combinational
- data_r_valid_o  out  N_MASTERS  response valid
- data_r_rdata_o  out  N_MASTERS*DATA_WIDTH  read data
- data_req_SRAM_o  out  N_SLAVES  bank chip-select
- data_add_SRAM_o  out  N_SLAVES*ADDR_SRAM_WIDTH  bank word address
- data_wen_SRAM_o  out  N_SLAVES  bank write-enable (0=store)
- data_wdata_SRAM_o  out  N_SLAVES*DATA_WIDTH  bank write data
- data_be_SRAM_o  out  N_SLAVES*BE_WIDTH  bank byte enables
- data_r_rdata_SRAM_i  in  N_SLAVES*DATA_WIDTH  bank read data, valid one cycle after req

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Address decode:
  - MSB_ADDR = LSB_ADDR + log2(N_SLAVES) - 1.
  - bank = (add - ADDR_OFFSET)[MSB_ADDR:LSB_ADDR], computed modulo 2^ADDR_WIDTH. Addresses outside the window alias; no error is flagged.
  - SRAM word address = add[ADDR_SRAM_WIDTH+1:2].
- Arbitration, per bank b:
  - Candidates are masters with req=1 and decoded bank==b.
  - The winner is the first candidate at or after rr_ptr[b], searching cyclically. Grant is issued the same cycle; at most one grant per bank per cycle.
  - On a grant: rr_ptr[b] <= winner+1 mod N_MASTERS. No candidate: the pointer holds.
- Bank-side outputs:
  - data_req_SRAM_o[b] = 1 iff bank b has a candidate; add/wen/wdata/be are muxed from the winner.
  - With no candidate, all bank-side outputs are 0.
- Protocol: a master holds req, add, wen, wdata and be stable until gnt. A master is never granted without req.
- Response path:
  - Registered per master: r_valid <= gnt; resp_bank <= granted bank.
  - data_r_valid_o is asserted exactly one cycle after the grant, for loads and stores alike.
  - data_r_rdata_o = data_r_rdata_SRAM_i[resp_bank] when r_valid=1, else 0.
  - Back-to-back grants to one master produce back-to-back valids.
- Reset values: rr_ptr=0, r_valid=0, resp_bank=0; data_r_rdata_o=0. Grant and bank outputs follow the inputs combinationally.
- Reset mid-operation:
  - Pending responses are dropped; r_valid is 0 during reset and in the first cycle after release.
  - Arbitration restarts from master 0.
- Simultaneous requests to distinct banks are all granted in the same cycle.

Optional Feature:
- HWCE_ARB_PERF_EN defined:
  - Adds ports perf_clr_i (in, 1) and conflict_cnt_o (out, 32).
  - Each cycle the counter adds popcount(req & ~gnt), saturating at 32'hFFFFFFFF.
  - perf_clr_i=1 clears the counter to 0; clear has priority over increment.
  - Reset value is 0.
- Undefined: the ports and the counter are absent.

Decomposition:
- Package hwce_arb_pkg: bank-index width constant, master-index width constant, saturating-add helper function.
- Sub-module hwce_rr_arb: N_MASTERS-input round-robin arbiter holding rr_ptr; outputs a one-hot grant and the winner index. One instance per bank.

Test Plan:
1. M0 reads bank 0, M1 reads bank 2, same cycle -> both gnt=1 in that cycle; both r_valid=1 one cycle later.
2. M0, M1, M2 hold requests to bank 3 for 6 cycles -> grants 0,1,2,0,1,2; data_req_SRAM_o[3]=1 every cycle; other banks idle.
3. M1 loads 0x00060000+(5<<17)+0x10 -> data_add_SRAM_o[5]=4, wen=1; bank returns 0xDEADBEEF -> M1 rdata=0xDEADBEEF with r_valid one cycle after gnt; other masters see rdata=0.
4. M2 stores 0xA5A5A5A5 with be=4'b0011 to bank 7 -> bank 7 sees wen=0, be=0011, wdata=0xA5A5A5A5; M2 r_valid next cycle.
5. Reset asserted while M3 and M1 contend on bank 1 after M3 was last granted -> r_valid=0; after release M1 is granted first (pointer at 0).
6. HWCE_ARB_PERF_EN, 3 masters on one bank for 4 cycles -> conflict_cnt_o=8; perf_clr_i pulse -> 0; preload near saturation -> holds 32'hFFFFFFFF.
